// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM state encoding and default parameters.
package btn_pkg;

  localparam logic [1:0] ST_UP      = 2'd0;
  localparam logic [1:0] ST_PEND_DN = 2'd1;
  localparam logic [1:0] ST_DOWN    = 2'd2;
  localparam logic [1:0] ST_PEND_UP = 2'd3;

  typedef enum logic [1:0] {
    StUp     = ST_UP,
    StPendDn = ST_PEND_DN,
    StDown   = ST_DOWN,
    StPendUp = ST_PEND_UP
  } btn_state_e;

  localparam int unsigned DefN         = 3;
  localparam int unsigned DefTickDiv   = 12000;
  localparam int unsigned DefDbTicks   = 20;
  localparam int unsigned DefHoldTicks = 1000;

endpackage

// File: rtl/db_channel.sv
// One debounce channel: qualification FSM, qual/hold counters and registered outputs.
module db_channel
  import btn_pkg::*;
#(
  parameter int unsigned DB_TICKS   = DefDbTicks,
  parameter int unsigned HOLD_TICKS = DefHoldTicks
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync_n,
  output logic db_n,
  output logic press,
  output logic rel,
  output logic hold
);

  localparam int unsigned QW = $clog2(DB_TICKS + 1);
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam logic [QW-1:0] QualLast = QW'(DB_TICKS - 1);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HoldMax  = HW'(HOLD_TICKS);

  btn_state_e    state_q, state_d;
  logic [QW-1:0] qual_q, qual_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          hold_q, hold_d;
  logic          db_n_q, db_n_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StUp;
      qual_q  <= '0;
      hcnt_q  <= '0;
      hold_q  <= 1'b0;
      db_n_q  <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qual_q  <= qual_d;
      hcnt_q  <= hcnt_d;
      hold_q  <= hold_d;
      db_n_q  <= db_n_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    hcnt_d  = hcnt_q;
    hold_d  = hold_q;
    db_n_d  = db_n_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      StUp: begin
        if (!sync_n) begin
          state_d = StPendDn;
          qual_d  = '0;
        end
      end
      StPendDn: begin
        // A revert on the qualifying tick wins: the press is abandoned.
        if (sync_n) begin
          state_d = StUp;
        end else if (tick) begin
          if (qual_q == QualLast) begin
            state_d = StDown;
            press_d = 1'b1;
            db_n_d  = 1'b0;
            hcnt_d  = '0;
          end else begin
            qual_d = qual_q + 1'b1;
          end
        end
      end
      StDown: begin
        if (tick) begin
          if (hcnt_q != HoldMax) hcnt_d = hcnt_q + 1'b1;
          if (hcnt_q == HoldLast) hold_d = 1'b1;
        end
        if (sync_n) begin
          state_d = StPendUp;
          qual_d  = '0;
        end
      end
      StPendUp: begin
        if (!sync_n) begin
          state_d = StDown;
        end else if (tick) begin
          if (qual_q == QualLast) begin
            state_d = StUp;
            rel_d   = 1'b1;
            db_n_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            qual_d = qual_q + 1'b1;
          end
        end
      end
      default: state_d = StUp;
    endcase
  end

  assign db_n  = db_n_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign hold  = hold_q;

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: per-channel two-flop synchronisers, a shared tick prescaler and
// one debounce channel per button.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned N          = DefN,
  parameter int unsigned TICK_DIV   = DefTickDiv,
  parameter int unsigned DB_TICKS   = DefDbTicks,
  parameter int unsigned HOLD_TICKS = DefHoldTicks
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_n,
  output logic [N-1:0] db_n,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic [N-1:0] hold
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PreLast = PW'(TICK_DIV - 1);

  logic [N-1:0]  sync0_q, sync1_q;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  // Synchronisers reset to released so nothing is seen as pressed out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0_q <= '1;
      sync1_q <= '1;
    end else begin
      sync0_q <= btn_n;
      sync1_q <= sync0_q;
    end
  end

  assign tick = (pre_q == PreLast);

  always_comb begin
    pre_d = pre_q + 1'b1;
    if (tick) pre_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= pre_d;
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    db_channel #(
      .DB_TICKS   (DB_TICKS),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .sync_n (sync1_q[i]),
      .db_n   (db_n[i]),
      .press  (press[i]),
      .rel    (rel[i]),
      .hold   (hold[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised and directed bench for btn_debounce against a level/pending reference model.
module tb_btn_debounce;

  localparam int unsigned N          = 3;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned DB_TICKS   = 3;
  localparam int unsigned HOLD_TICKS = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_n = '1;
  logic [N-1:0] db_n, press, rel, hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_debounce #(
    .N          (N),
    .TICK_DIV   (TICK_DIV),
    .DB_TICKS   (DB_TICKS),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_n),
    .db_n  (db_n),
    .press (press),
    .rel   (rel),
    .hold  (hold)
  );

  // Reference: accepted level plus "a different level is pending" and ticks seen while pending.
  logic [N-1:0] m_s0, m_s1, m_acc, m_pend, m_press, m_rel, m_hold;
  int           m_pre;
  int           m_cnt [N];
  int           m_hcnt[N];

  int cyc = 0;
  int press_cnt[N];
  int rel_cnt[N];
  int last_press[N];
  int last_rel[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s0 = '1; m_s1 = '1; m_acc = '1; m_pend = '0;
    m_press = '0; m_rel = '0; m_hold = '0; m_pre = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_hcnt[i] = 0;
    end
  endtask

  task automatic model_step();
    logic         tk;
    logic [N-1:0] s;
    tk = (m_pre == TICK_DIV - 1);
    s  = m_s1;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < N; i++) begin
      if (!m_acc[i] && !m_pend[i] && tk) begin
        if (m_hcnt[i] < HOLD_TICKS) m_hcnt[i]++;
        if (m_hcnt[i] == HOLD_TICKS) m_hold[i] = 1'b1;
      end
      if (!m_pend[i]) begin
        if (s[i] != m_acc[i]) begin
          m_pend[i] = 1'b1;
          m_cnt[i]  = 0;
        end
      end else if (s[i] == m_acc[i]) begin
        m_pend[i] = 1'b0;
      end else if (tk) begin
        m_cnt[i]++;
        if (m_cnt[i] == DB_TICKS) begin
          m_acc[i]  = s[i];
          m_pend[i] = 1'b0;
          if (!s[i]) begin
            m_press[i] = 1'b1;
            m_hcnt[i]  = 0;
          end else begin
            m_rel[i]  = 1'b1;
            m_hold[i] = 1'b0;
          end
        end
      end
    end
    m_s1  = m_s0;
    m_s0  = btn_n;
    m_pre = (m_pre + 1) % TICK_DIV;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; last_press[i] = -1; last_rel[i] = -1;
    end
  endtask

  task automatic cycle(input logic [N-1:0] b);
    btn_n = b;
    @(posedge clk);
    if (rst) model_step();
    else     model_reset();
    #1;
    cyc++;
    check("db_n", 32'(db_n), 32'(m_acc));
    check("press", 32'(press), 32'(m_press));
    check("release", 32'(rel), 32'(m_rel));
    check("hold", 32'(hold), 32'(m_hold));
    for (int i = 0; i < N; i++) begin
      if (press[i]) begin press_cnt[i]++; last_press[i] = cyc; end
      if (rel[i])   begin rel_cnt[i]++;   last_rel[i]   = cyc; end
    end
  endtask

  task automatic run(input logic [N-1:0] b, input int n);
    for (int k = 0; k < n; k++) cycle(b);
  endtask

  initial begin
    int start;
    int len[N];
    logic [N-1:0] rb;

    model_reset();
    clear_counts();
    btn_n = 3'b000;
    #12;
    check("rst_db_n", 32'(db_n), 32'h7);
    check("rst_press", 32'(press), 32'h0);
    check("rst_release", 32'(rel), 32'h0);
    check("rst_hold", 32'(hold), 32'h0);
    rst = 1'b1;

    // Button held through reset is re-qualified after release.
    start = cyc;
    run(3'b000, 25);
    check("rst_requal_cnt", 32'(press_cnt[0]), 32'd1);
    check("rst_requal_lat", 32'(last_press[0] - start >= int'(3 * TICK_DIV)), 32'd1);
    run(3'b111, 20);

    // Clean press and release on ch0.
    clear_counts();
    start = cyc;
    run(3'b110, 20);
    check("clean_press_cnt", 32'(press_cnt[0]), 32'd1);
    check("clean_press_lat", 32'((last_press[0] - start >= 12) && (last_press[0] - start <= 15)),
          32'd1);
    check("clean_db_low", 32'(db_n[0]), 32'd0);
    start = cyc;
    run(3'b111, 20);
    check("clean_rel_cnt", 32'(rel_cnt[0]), 32'd1);
    check("clean_rel_lat", 32'((last_rel[0] - start >= 12) && (last_rel[0] - start <= 15)), 32'd1);
    check("clean_db_high", 32'(db_n[0]), 32'd1);

    // Bounce on ch1: five-cycle pulses can never reach three ticks.
    clear_counts();
    for (int k = 0; k < 60; k++) cycle(((k / 5) % 2) != 0 ? 3'b111 : 3'b101);
    check("bounce_no_press", 32'(press_cnt[1]), 32'd0);
    run(3'b101, 20);
    check("bounce_then_press", 32'(press_cnt[1]), 32'd1);
    run(3'b111, 20);

    // Sweep press widths across the qualifying-tick race window.
    for (int l = 6; l <= 14; l++) begin
      run(3'b101, l);
      run(3'b111, 25);
    end

    // Long press on ch2 with a short release bounce.
    clear_counts();
    run(3'b011, 40);
    check("long_hold_set", 32'(hold[2]), 32'd1);
    run(3'b111, 3);
    run(3'b011, 10);
    check("long_hold_bounce", 32'(hold[2]), 32'd1);
    check("long_no_release", 32'(rel_cnt[2]), 32'd0);
    run(3'b111, 25);
    check("long_hold_clear", 32'(hold[2]), 32'd0);
    check("long_hold_fall_at_rel", 32'(rel_cnt[2]), 32'd1);

    // Concurrent presses on ch0 and ch1.
    clear_counts();
    run(3'b100, 20);
    check("conc_same_cycle", 32'(last_press[0] == last_press[1] && last_press[0] > 0), 32'd1);
    check("conc_ch2_idle", 32'(press_cnt[2]), 32'd0);
    run(3'b111, 20);

    // Random per-channel levels with random run lengths.
    rb = '1;
    for (int i = 0; i < N; i++) len[i] = $urandom_range(1, 25);
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++) begin
        len[i]--;
        if (len[i] <= 0) begin
          rb[i]  = ~rb[i];
          len[i] = $urandom_range(1, 25);
        end
      end
      cycle(rb);
    end

    // Asynchronous reset mid-press.
    run(3'b000, 30);
    rst = 1'b0;
    #1;
    check("midrst_db_n", 32'(db_n), 32'h7);
    check("midrst_hold", 32'(hold), 32'h0);
    model_reset();
    run(3'b000, 2);
    rst = 1'b1;
    clear_counts();
    run(3'b000, 10);
    check("midrst_no_pulse", 32'(press_cnt[0] + rel_cnt[0]), 32'd0);
    run(3'b000, 20);
    run(3'b111, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
